if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It holds the PC, issues requests to instruction memory over a req/ack handshake, and writes the IF/ID pipeline register consumed by decode and by the hazard detection unit. It obeys the hazard unit's PC-hold and IF/ID-hold outputs and the branch/jump redirect and flush from ID. A one-entry hold buffer catches a returning instruction while IF/ID is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: fetch enable. While 0, no new request is launched.
- `stall_pc_i` in 1: hazard unit PC hold. 1 = launch no new request and do not advance the PC this cycle.
- `stall_ifid_i` in 1: hazard unit IF/ID hold. 1 = IF/ID keeps its value.
- `flush_i` in 1: squash IF/ID (taken branch/jump).
- `redirect_i` in 1: load a new PC.
- `redirect_pc_i` in 32: redirect target.
- `imem_req_o` out 1: memory request.
- `imem_addr_o` out 32: request address.
- `imem_ack_i` in 1: memory ack. It may be asserted in the same cycle as `imem_req_o`.
- `imem_data_i` in 32: instruction, valid while ack = 1.
- `ifid_pc_o` out 32: PC+4 of the instruction in IF/ID.
- `ifid_inst_o` out 32: IF/ID instruction.
- `ifid_valid_o` out 1: IF/ID holds a real instruction.
- `fetch_pending_o` out 1: 1 while a memory request is outstanding.

## Operation
- **FSM states:** IDLE, REQ, HOLD, DROP.
- **Handshake rule:** once `imem_req_o` rises, it and `imem_addr_o` stay stable until the cycle with `imem_ack_i` = 1. A request is never withdrawn except by reset.
- **IDLE** (req = 0):
  - start_i = 1 and stall_pc_i = 0 → REQ.
  - redirect_i = 1 → pc <= redirect_pc_i, state stays IDLE.
- **REQ** (req = 1, addr = pc):
  - redirect_i = 1, no ack → pc <= redirect_pc_i, go to DROP.
  - redirect_i = 1 with ack → data discarded, pc <= redirect_pc_i, go to IDLE.
  - ack, no redirect, stall_ifid_i = 0 → IF/ID <= {pc+4, data, valid 1}; pc <= pc+4.
  - ack, no redirect, stall_ifid_i = 1 → buffer <= {pc+4, data}; pc <= pc+4; go to HOLD.
  - Next state after an accepted ack: REQ if start_i = 1 and stall_pc_i = 0, else IDLE.
- **HOLD** (req = 0):
  - redirect_i = 1 → buffer discarded, pc <= redirect_pc_i, go to IDLE.
  - stall_ifid_i = 0 → IF/ID <= {buffer, valid 1}. Next state follows the same rule as REQ.
- **DROP** (req = 1, old address held):
  - On ack, data discarded, go to IDLE.
  - A further redirect_i overwrites pc.
- **IF/ID update priority, per cycle:**
  1. flush_i = 1 → pc/inst <= 0, valid <= 0. This overrides stall_ifid_i.
  2. stall_ifid_i = 1 → hold.
  3. Otherwise load the accepted instruction, or a bubble (valid 0, inst 0, pc 0) if none is available.
- **PC arithmetic:** 32-bit, wraps from 32'hFFFF_FFFC to 0. Bits [1:0] pass through unmodified.
- **fetch_pending_o** = 1 in REQ and DROP.

## Timing
- **Reset values:** pc = RESET_PC, state IDLE, imem_req_o = 0, imem_addr_o = RESET_PC, ifid_pc_o = 0, ifid_inst_o = 0, ifid_valid_o = 0, fetch_pending_o = 0, buffer = 0.
- **Reset mid-request:** req drops on the next edge. Instruction memory shares rst_i and abandons the request.
- **Latency:** an ack in cycle N appears on the IF/ID outputs after edge N+1.
- **Throughput:** with same-cycle ack and no stalls, one instruction per cycle and req stays high continuously.
- **Memory wait cycles:** each cycle without ack and without stall_ifid_i inserts one bubble into IF/ID.
- **flush_i and redirect_i together:** both take effect on the same edge, so no wrong-path instruction ever reaches IF/ID valid.
- **stall_pc_i = 1 in REQ:** the outstanding request still completes.

## Test plan
- **Streaming:** reset with RESET_PC = 0, start_i = 1, ack every cycle, data = addr ^ 32'hA5A5_A5A5 → ifid_pc_o is 4, 8, 12… one per cycle with valid = 1.
- **Load-use stall:** stall_pc_i = stall_ifid_i = 1 for 1 cycle while an instruction at PC 8 is acked → HOLD. IF/ID keeps PC 8's predecessor, then shows {12, inst@8}. Next request is addr 12.
- **Redirect during wait:** req at addr 16 with ack delayed 3 cycles, redirect_i = 1 to 32'h100 in the first cycle → DROP with addr held at 16. The ack data is discarded, the next request is addr 32'h100, and valid stays 0 throughout.
- **Flush overrides stall:** flush_i = 1 with stall_ifid_i = 1 → IF/ID valid = 0, inst = 0 next cycle.
- **Wrap:** RESET_PC = 32'hFFFF_FFFC, one fetch → ifid_pc_o = 0, next addr 0.
- **Reset mid-request:** rst_i = 0 while in REQ with no ack → req = 0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// writes the IF/ID register, with a one-entry hold buffer for stalled returns.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_pc_i,
  input  logic        stall_ifid_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_inst_o,
  output logic        ifid_valid_o,
  output logic        fetch_pending_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] drop_addr, drop_addr_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] buf_inst, buf_inst_nx;
  logic        take_valid;
  logic [31:0] take_pc, take_inst;
  logic [31:0] pc_plus4;
  logic        launch_ok;

  assign pc_plus4  = pc + 32'd4;
  assign launch_ok = start_i & ~stall_pc_i;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nx     = state;
    pc_nx        = pc;
    drop_addr_nx = drop_addr;
    buf_pc_nx    = buf_pc;
    buf_inst_nx  = buf_inst;
    take_valid   = 1'b0;
    take_pc      = 32'd0;
    take_inst    = 32'd0;
    case (state)
      S_IDLE: begin
        if (redirect_i)     pc_nx    = redirect_pc_i;
        else if (launch_ok) state_nx = S_REQ;
      end
      S_REQ: begin
        if (redirect_i) begin
          pc_nx = redirect_pc_i;
          if (imem_ack_i) begin
            state_nx = S_IDLE;
          end else begin
            // The request in flight keeps its address until memory answers.
            state_nx     = S_DROP;
            drop_addr_nx = pc;
          end
        end else if (imem_ack_i) begin
          pc_nx = pc_plus4;
          if (stall_ifid_i) begin
            buf_pc_nx   = pc_plus4;
            buf_inst_nx = imem_data_i;
            state_nx    = S_HOLD;
          end else begin
            take_valid = 1'b1;
            take_pc    = pc_plus4;
            take_inst  = imem_data_i;
            state_nx   = launch_ok ? S_REQ : S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_nx       = redirect_pc_i;
          buf_pc_nx   = 32'd0;
          buf_inst_nx = 32'd0;
          state_nx    = S_IDLE;
        end else if (!stall_ifid_i) begin
          take_valid  = 1'b1;
          take_pc     = buf_pc;
          take_inst   = buf_inst;
          buf_pc_nx   = 32'd0;
          buf_inst_nx = 32'd0;
          state_nx    = launch_ok ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_i) pc_nx    = redirect_pc_i;
        if (imem_ack_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      drop_addr    <= RESET_PC;
      buf_pc       <= 32'd0;
      buf_inst     <= 32'd0;
      ifid_pc_o    <= 32'd0;
      ifid_inst_o  <= 32'd0;
      ifid_valid_o <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop_addr <= drop_addr_nx;
      buf_pc    <= buf_pc_nx;
      buf_inst  <= buf_inst_nx;
      // Flush beats the hold; with nothing accepted a bubble is loaded.
      if (flush_i) begin
        ifid_pc_o    <= 32'd0;
        ifid_inst_o  <= 32'd0;
        ifid_valid_o <= 1'b0;
      end else if (!stall_ifid_i) begin
        ifid_pc_o    <= take_pc;
        ifid_inst_o  <= take_inst;
        ifid_valid_o <= take_valid;
      end
    end
  end

  assign imem_req_o      = (state == S_REQ) || (state == S_DROP);
  assign fetch_pending_o = imem_req_o;
  assign imem_addr_o     = (state == S_DROP) ? drop_addr : pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: two instances (RESET_PC 0 and 32'hFFFF_FFFC) driven
// in lock-step, checked every cycle against a transaction-level fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst, start, stall_pc, stall_ifid, flush, redirect, ack;
  logic [31:0] redirect_pc;
  logic        req     [2];
  logic [31:0] addr    [2];
  logic [31:0] data    [2];
  logic [31:0] ifid_pc [2];
  logic [31:0] inst    [2];
  logic        valid   [2];
  logic        pending [2];

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  assign data[0] = addr[0] ^ KEY;
  assign data[1] = addr[1] ^ KEY;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_pc_i(stall_pc),
    .stall_ifid_i(stall_ifid), .flush_i(flush), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req[0]), .imem_addr_o(addr[0]),
    .imem_ack_i(ack), .imem_data_i(data[0]), .ifid_pc_o(ifid_pc[0]),
    .ifid_inst_o(inst[0]), .ifid_valid_o(valid[0]), .fetch_pending_o(pending[0])
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_pc_i(stall_pc),
    .stall_ifid_i(stall_ifid), .flush_i(flush), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req[1]), .imem_addr_o(addr[1]),
    .imem_ack_i(ack), .imem_data_i(data[1]), .ifid_pc_o(ifid_pc[1]),
    .ifid_inst_o(inst[1]), .ifid_valid_o(valid[1]), .fetch_pending_o(pending[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a fetch is either outstanding (possibly doomed), parked, or absent.
  logic [31:0] m_pc       [2];
  bit          m_out      [2];
  logic [31:0] m_out_addr [2];
  bit          m_doomed   [2];
  bit          m_park_v   [2];
  logic [31:0] m_park_pc  [2];
  logic [31:0] m_park_ins [2];
  logic [31:0] m_if_pc    [2];
  logic [31:0] m_if_ins   [2];
  bit          m_if_v     [2];

  function automatic logic [31:0] reset_pc(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic model_step(input int k);
    bit          got_v  = 1'b0;
    logic [31:0] got_pc = 32'd0;
    logic [31:0] got_in = 32'd0;
    bit          launch = 1'b0;
    if (!rst) begin
      m_pc[k] = reset_pc(k); m_out[k] = 1'b0; m_out_addr[k] = reset_pc(k);
      m_doomed[k] = 1'b0; m_park_v[k] = 1'b0; m_park_pc[k] = 32'd0; m_park_ins[k] = 32'd0;
      m_if_pc[k] = 32'd0; m_if_ins[k] = 32'd0; m_if_v[k] = 1'b0;
      return;
    end
    if (m_out[k]) begin
      if (ack) begin
        m_out[k] = 1'b0;
        if (!m_doomed[k] && !redirect) begin
          m_pc[k] = m_out_addr[k] + 32'd4;
          if (stall_ifid) begin
            m_park_v[k] = 1'b1; m_park_pc[k] = m_pc[k]; m_park_ins[k] = m_out_addr[k] ^ KEY;
          end else begin
            got_v = 1'b1; got_pc = m_pc[k]; got_in = m_out_addr[k] ^ KEY;
            launch = start && !stall_pc;
          end
        end
      end else if (redirect) begin
        m_doomed[k] = 1'b1;
      end
      if (redirect) m_pc[k] = redirect_pc;
    end else if (m_park_v[k]) begin
      if (redirect) begin
        m_park_v[k] = 1'b0; m_pc[k] = redirect_pc;
      end else if (!stall_ifid) begin
        got_v = 1'b1; got_pc = m_park_pc[k]; got_in = m_park_ins[k];
        m_park_v[k] = 1'b0;
        launch = start && !stall_pc;
      end
    end else begin
      if (redirect) m_pc[k] = redirect_pc;
      else          launch = start && !stall_pc;
    end
    if (launch) begin
      m_out[k] = 1'b1; m_out_addr[k] = m_pc[k]; m_doomed[k] = 1'b0;
    end
    if (flush) begin
      m_if_pc[k] = 32'd0; m_if_ins[k] = 32'd0; m_if_v[k] = 1'b0;
    end else if (!stall_ifid) begin
      m_if_pc[k] = got_pc; m_if_ins[k] = got_in; m_if_v[k] = got_v;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("d%0d req", k),     32'(req[k]),     32'(m_out[k]));
        check($sformatf("d%0d pending", k), 32'(pending[k]), 32'(m_out[k]));
        if (m_out[k]) check($sformatf("d%0d addr", k), addr[k], m_out_addr[k]);
        check($sformatf("d%0d ifid_pc", k),    ifid_pc[k],    m_if_pc[k]);
        check($sformatf("d%0d ifid_inst", k),  inst[k],       m_if_ins[k]);
        check($sformatf("d%0d ifid_valid", k), 32'(valid[k]), 32'(m_if_v[k]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pin_ifid(input string name, input logic [31:0] p, input logic [31:0] i,
                          input logic v);
    check({name, " pc"},    ifid_pc[0],    p);
    check({name, " inst"},  inst[0],       i);
    check({name, " valid"}, 32'(valid[0]), 32'(v));
  endtask

  task automatic pin_req(input string name, input logic r, input logic [31:0] a);
    check({name, " req"}, 32'(req[0]), 32'(r));
    if (r) check({name, " addr"}, addr[0], a);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall_pc = 1'b0; stall_ifid = 1'b0;
    flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; ack = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    // Reset values
    pin_ifid("reset", 32'd0, 32'd0, 1'b0);
    pin_req("reset", 1'b0, 32'd0);
    check("reset addr0", addr[0], 32'h0000_0000);
    check("reset addr1", addr[1], 32'hFFFF_FFFC);
    check("reset pending", 32'(pending[0]), 32'd0);

    // Streaming with same-cycle ack
    rst = 1'b1; start = 1'b1; ack = 1'b1;
    step();
    pin_req("launch", 1'b1, 32'h0);
    step();
    pin_ifid("stream0", 32'd4, 32'hA5A5_A5A5, 1'b1);
    check("wrap ifid_pc", ifid_pc[1], 32'h0000_0000);
    check("wrap inst", inst[1], 32'h5A5A_5A59);
    check("wrap next addr", addr[1], 32'h0000_0004 - 32'd4);
    step();
    pin_ifid("stream1", 32'd8, 32'hA5A5_A5A1, 1'b1);
    pin_req("stream1", 1'b1, 32'd8);

    // Load-use stall while PC 8 is acked
    stall_pc = 1'b1; stall_ifid = 1'b1;
    step();
    pin_ifid("loaduse hold", 32'd8, 32'hA5A5_A5A1, 1'b1);
    pin_req("loaduse hold", 1'b0, 32'd0);
    stall_pc = 1'b0; stall_ifid = 1'b0;
    step();
    pin_ifid("loaduse release", 32'd12, 32'hA5A5_A5AD, 1'b1);
    pin_req("loaduse release", 1'b1, 32'd12);
    step();
    pin_req("stream2", 1'b1, 32'd16);

    // Redirect while the request at 16 waits three cycles
    ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    pin_req("drop w1", 1'b1, 32'd16);
    check("drop w1 valid", 32'(valid[0]), 32'd0);
    step();
    pin_req("drop w2", 1'b1, 32'd16);
    step();
    pin_req("drop w3", 1'b1, 32'd16);
    ack = 1'b1;
    step();
    pin_ifid("drop ack", 32'd0, 32'd0, 1'b0);
    pin_req("drop ack", 1'b0, 32'd0);
    step();
    pin_req("after drop", 1'b1, 32'h100);
    check("after drop valid", 32'(valid[0]), 32'd0);
    step();
    pin_ifid("redirect target", 32'h104, 32'hA5A5_A4A5, 1'b1);

    // Flush overrides stall
    flush = 1'b1; stall_ifid = 1'b1;
    step();
    pin_ifid("flush+stall", 32'd0, 32'd0, 1'b0);
    flush = 1'b0; stall_ifid = 1'b0;
    step();
    pin_ifid("after flush", 32'h108, 32'hA5A5_A4A1, 1'b1);
    pin_req("after flush", 1'b1, 32'h108);

    // Redirect + flush together on an acked request
    redirect = 1'b1; redirect_pc = 32'h200; flush = 1'b1;
    step();
    redirect = 1'b0; flush = 1'b0;
    pin_ifid("redir+flush", 32'd0, 32'd0, 1'b0);
    pin_req("redir+flush", 1'b0, 32'd0);
    step();
    pin_req("redir launch", 1'b1, 32'h200);

    // Memory wait cycles insert bubbles
    ack = 1'b0;
    step();
    pin_ifid("wait1", 32'd0, 32'd0, 1'b0);
    step();
    pin_req("wait2", 1'b1, 32'h200);
    ack = 1'b1;
    step();
    pin_ifid("wait done", 32'h204, 32'hA5A5_A7A5, 1'b1);

    // Reset mid-request
    ack = 1'b0;
    step();
    pin_req("pre-reset", 1'b1, 32'h204);
    rst = 1'b0;
    step();
    pin_ifid("mid reset", 32'd0, 32'd0, 1'b0);
    pin_req("mid reset", 1'b0, 32'd0);
    check("mid reset pending", 32'(pending[0]), 32'd0);
    check("mid reset addr0", addr[0], 32'h0000_0000);
    check("mid reset addr1", addr[1], 32'hFFFF_FFFC);

    // Mixed traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      start       = ($urandom_range(0, 7) != 0);
      stall_pc    = ($urandom_range(0, 3) == 0);
      stall_ifid  = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      ack         = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
